// File: rtl/gpr_pkg.sv
// gpr_pkg: shared types, constants and helpers for the multi-port register file.
//   gpr_state_e  : clear-engine state (CLEAR while zeroing, RUN when usable)
//   GPR_ZERO_IDX : index of the hardwired-zero register
//   gpr_aw()     : address width for a given register count
package gpr_pkg;
   typedef enum logic {CLEAR, RUN} gpr_state_e;
   localparam int GPR_ZERO_IDX = 0;
   function automatic int gpr_aw(input int nreg);
      return $clog2(nreg);
   endfunction
endpackage

// File: rtl/gpr_file_mp_if.sv
// gpr_file_mp_if: decode/writeback/debug bus of the register file.
//   ready              : clear done, file usable
//   raddr/rdata        : NRD read ports, port i in slice i
//   wen/waddr/wdata    : NWR write ports, port j in slice j
//   dbg_addr/dbg_data  : unbypassed debug read port
//   master = consumer (decode/writeback), slave = register file
interface gpr_file_mp_if import gpr_pkg::*; #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
);
   localparam int AW = gpr_aw(NREG);
   logic                ready;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NWR-1:0]      wen;
   logic [NWR*AW-1:0]   waddr;
   logic [NWR*XLEN-1:0] wdata;
   logic [AW-1:0]       dbg_addr;
   logic [XLEN-1:0]     dbg_data;
   modport master (input ready, rdata, dbg_data, output raddr, wen, waddr, wdata, dbg_addr);
   modport slave  (output ready, rdata, dbg_data, input raddr, wen, waddr, wdata, dbg_addr);
endinterface

// File: rtl/gpr_read_port.sv
// gpr_read_port: one combinational read port of the register file.
//   run    : file is in RUN and out of reset; otherwise data is forced to 0
//   raddr  : read address
//   regs   : register array
//   wen/waddr/wdata : write ports, used for same-cycle bypass when BYPASS=1
//   rdata  : read data
module gpr_read_port import gpr_pkg::*; #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = gpr_aw(NREG)
) (
   input  logic                run,
   input  logic [AW-1:0]       raddr,
   input  logic [XLEN-1:0]     regs [NREG],
   input  logic [NWR-1:0]      wen,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   output logic [XLEN-1:0]     rdata
);
   // later ports overwrite earlier matches, so the highest-index writer wins
   always_comb begin
      rdata = regs[raddr];
      if (BYPASS != 0)
         for (int j = 0; j < NWR; j++)
            if (wen[j] && waddr[j*AW +: AW] == raddr) rdata = wdata[j*XLEN +: XLEN];
      if (!run || raddr == AW'(GPR_ZERO_IDX)) rdata = '0;
   end
endmodule

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised multi-port register file with clear engine.
//   clk  : clock
//   rst  : synchronous active-low reset; restarts the clear engine
//   bus  : slave side of gpr_file_mp_if (ready, read, write and debug ports)
// Register 0 is hardwired zero; after reset every other register is zeroed
// one per cycle before ready rises.
module gpr_file_mp import gpr_pkg::*; #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
) (
   input logic clk,
   input logic rst,
   gpr_file_mp_if.slave bus
);
   localparam int AW = gpr_aw(NREG);
   gpr_state_e      state, state_nx;
   logic [AW-1:0]   clr_cnt;
   logic [XLEN-1:0] regs [NREG];
   logic            run;
   // reset forces outputs to zero immediately, not just after the reset edge
   assign run = rst && state == RUN;
   assign bus.ready = state == RUN;
   always_comb state_nx = (state == CLEAR && clr_cnt == AW'(NREG - 1)) ? RUN : state;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= CLEAR;
         clr_cnt <= AW'(1);
      end else begin
         state <= state_nx;
         if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
      end
   end
   // contents are not reset; the clear engine zeroes them instead, and
   // the last enabled port in loop order takes priority on a conflict
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == CLEAR) regs[clr_cnt] <= '0;
         else
            for (int j = 0; j < NWR; j++)
               if (bus.wen[j] && bus.waddr[j*AW +: AW] != AW'(GPR_ZERO_IDX))
                  regs[bus.waddr[j*AW +: AW]] <= bus.wdata[j*XLEN +: XLEN];
      end
   end
   assign bus.dbg_data = (run && bus.dbg_addr != AW'(GPR_ZERO_IDX)) ? regs[bus.dbg_addr] : '0;
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      gpr_read_port #(.XLEN(XLEN), .NREG(NREG), .NWR(NWR), .BYPASS(BYPASS)) u_rd (
         .run   (run),
         .raddr (bus.raddr[i*AW +: AW]),
         .regs  (regs),
         .wen   (bus.wen),
         .waddr (bus.waddr),
         .wdata (bus.wdata),
         .rdata (bus.rdata[i*XLEN +: XLEN])
      );
   end
endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: scoreboard bench for gpr_file_mp (bypass and no-bypass builds).
module tb_gpr_file_mp;
   import gpr_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   gpr_file_mp_if #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2)) b1 ();
   gpr_file_mp_if #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2)) b0 ();
   gpr_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );
   gpr_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );
   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;
   exp_t sb[$];
   int npass = 0;
   int ntot  = 0;
   localparam int RD0 = 0, RD1 = 1, DBG = 2, NB0 = 3, RDY = 4;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      if (obs === exp) npass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask
   function automatic logic [63:0] observe(input int sel);
      case (sel)
         RD0:     return b1.rdata[63:0];
         RD1:     return b1.rdata[127:64];
         DBG:     return b1.dbg_data;
         NB0:     return b0.rdata[63:0];
         default: return 64'(b1.ready);
      endcase
   endfunction
   task automatic expect_out(input string tag, input int sel, input logic [63:0] exp);
      sb.push_back('{tag, sel, exp});
   endtask
   task automatic drain();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
   endtask
   task automatic idle();
      b1.wen = '0;
      b0.wen = '0;
   endtask
   task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d);
      b1.wen[p] = 1'b1;
      b1.waddr[p*5 +: 5] = a;
      b1.wdata[p*64 +: 64] = d;
   endtask
   task automatic wr_nb(input logic [4:0] a, input logic [63:0] d);
      b0.wen = 2'b01;
      b0.waddr[4:0] = a;
      b0.wdata[63:0] = d;
   endtask
   // counts cycles with ready low from the release negedge; optionally pulses
   // a write to reg 4 mid-clear and checks reads are still forced to zero
   task automatic clear_wait(input string tag, input bit pulse);
      int n = 0;
      while (b1.ready !== 1'b1 && n < 200) begin
         if (pulse && n == 20) begin
            wr(0, 5'd4, 64'h99);
            b1.raddr[4:0] = 5'd3;
            b1.dbg_addr = 5'd3;
            expect_out("clr_rd0", RD0, 64'h0);
            expect_out("clr_dbg", DBG, 64'h0);
            expect_out("clr_rdy", RDY, 64'h0);
            drain();
         end
         n++;
         @(negedge clk);
         idle();
      end
      check(tag, 64'(n), 64'd31);
   endtask
   initial begin
      b1.raddr = '0; b1.wen = '0; b1.waddr = '0; b1.wdata = '0; b1.dbg_addr = '0;
      b0.raddr = '0; b0.wen = '0; b0.waddr = '0; b0.wdata = '0; b0.dbg_addr = '0;
      repeat (3) @(negedge clk);
      expect_out("rst_ready", RDY, 64'h0);
      expect_out("rst_rd0", RD0, 64'h0);
      drain();
      rst = 1'b1;
      clear_wait("clear1", 1'b0);
      wr(0, 5'd5, 64'hBAD0_BAD0_BAD0_BAD0);
      b1.dbg_addr = 5'd5;
      @(negedge clk);
      idle();
      expect_out("preload5", DBG, 64'hBAD0_BAD0_BAD0_BAD0);
      drain();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      clear_wait("clear2", 1'b0);
      expect_out("cleared5", DBG, 64'h0);
      drain();
      @(negedge clk);
      wr(0, 5'd3, 64'hDEADBEEF_00000001);
      b1.raddr[4:0] = 5'd3;
      b1.dbg_addr = 5'd3;
      expect_out("byp_rd0", RD0, 64'hDEADBEEF_00000001);
      expect_out("dbg_old", DBG, 64'h0);
      drain();
      @(negedge clk);
      idle();
      expect_out("wr_rd0", RD0, 64'hDEADBEEF_00000001);
      expect_out("dbg_new", DBG, 64'hDEADBEEF_00000001);
      drain();
      @(negedge clk);
      expect_out("wr_rd0_2", RD0, 64'hDEADBEEF_00000001);
      drain();
      @(negedge clk);
      wr(0, 5'd0, 64'hFFFF);
      wr(1, 5'd0, 64'hFFFF);
      b1.raddr = '0;
      b1.dbg_addr = 5'd0;
      expect_out("r0_rd0", RD0, 64'h0);
      expect_out("r0_rd1", RD1, 64'h0);
      expect_out("r0_dbg", DBG, 64'h0);
      drain();
      @(negedge clk);
      idle();
      expect_out("r0_rd0_n", RD0, 64'h0);
      expect_out("r0_rd1_n", RD1, 64'h0);
      expect_out("r0_dbg_n", DBG, 64'h0);
      drain();
      @(negedge clk);
      wr(0, 5'd7, 64'h11);
      wr(1, 5'd7, 64'h22);
      b1.raddr[9:5] = 5'd7;
      expect_out("conf_byp", RD1, 64'h22);
      drain();
      @(negedge clk);
      idle();
      b1.dbg_addr = 5'd7;
      expect_out("conf_dbg", DBG, 64'h22);
      expect_out("conf_rd1", RD1, 64'h22);
      drain();
      @(negedge clk);
      wr_nb(5'd9, 64'h44);
      b0.raddr[4:0] = 5'd9;
      expect_out("nb_init", NB0, 64'h0);
      drain();
      @(negedge clk);
      wr_nb(5'd9, 64'h55);
      expect_out("nb_same", NB0, 64'h44);
      drain();
      @(negedge clk);
      idle();
      expect_out("nb_next", NB0, 64'h55);
      drain();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      b1.raddr[4:0] = 5'd3;
      expect_out("rst_rd_run", RD0, 64'h0);
      expect_out("rst_rdy_run", RDY, 64'h0);
      drain();
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      clear_wait("clear_mid", 1'b1);
      b1.raddr[4:0] = 5'd4;
      b1.dbg_addr = 5'd4;
      expect_out("mid_rd4", RD0, 64'h0);
      expect_out("mid_dbg4", DBG, 64'h0);
      drain();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/gpr_file_mp.md
# gpr_file_mp

Parametrised multi-port general-purpose register file for the npc core. It replaces the fixed 2-read/1-write 64×32 file and adds configurable read and write port counts, same-cycle write-to-read bypass, and a debug read port. A sequential clear engine zeroes every register after reset and signals completion with `ready`. It sits between decode (read addresses) and writeback (write ports).

## Interface
- `XLEN`, 64, register width in bits
- `NREG`, 32, register count; power of two, ≥4; `AW = $clog2(NREG)`
- `NRD`, 2, number of read ports
- `NWR`, 2, number of write ports
- `BYPASS`, 1, 1 = a read sees same-cycle write data; 0 = a read sees the old value
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-low`
- `ready  out  1  1 = clear done, file usable`
- `raddr  in  NRD*AW  read addresses; port i is slice i`
- `rdata  out  NRD*XLEN  read data; port i is slice i`
- `wen  in  NWR  write enables`
- `waddr  in  NWR*AW  write addresses`
- `wdata  in  NWR*XLEN  write data`
- `dbg_addr  in  AW  debug read address`
- `dbg_data  out  XLEN  debug read data; never bypassed`

## Operation
- **Reset.** On a posedge with `rst`=0:
  - state←CLEAR, `clr_cnt`←1, `ready`←0.
  - Outputs during reset: `rdata`=0, `dbg_data`=0.
  - Register contents are not directly reset.
- **CLEAR state.** Each posedge with `rst`=1:
  - regs[`clr_cnt`]←0, then `clr_cnt`++.
  - When `clr_cnt`==NREG−1 at the edge: state←RUN, `ready`←1.
  - While in CLEAR, all `wen` are ignored and all `rdata`/`dbg_data` read 0.
- **RUN state.** This state holds until `rst`=0.
- **Register 0.** Hardwired zero:
  - Writes to it are dropped.
  - Reads of it return 0 on every port, including bypass.
- **Writes (RUN only).**
  - For each port j with `wen[j]` and `waddr[j]`≠0: regs[`waddr[j]`]←`wdata[j]`.
  - If several enabled ports target the same address, the highest port index wins.
- **Reads (combinational, RUN only).**
  - `rdata[i]` = regs[`raddr[i]`].
  - If `BYPASS`=1 and some enabled port j has `waddr[j]`==`raddr[i]`≠0, `rdata[i]` = `wdata` of the highest such j.
- **Debug read.** `dbg_data` = regs[`dbg_addr`] in RUN. It has no bypass.

## Timing
- Clear latency: `ready` rises NREG−1 cycles after the first posedge with `rst`=1. For NREG=32, that is 31 cycles.
- Write to read latency:
  - `BYPASS`=1: the value is visible in the same cycle (combinational).
  - `BYPASS`=0: the value is visible in the cycle after the write edge.
- Reset during CLEAR: the count restarts at 1, and `ready` stays 0 for the full NREG−1 cycles after release.
- Reset during RUN: `ready` falls at that edge, and the clear engine reruns after release.
- A write asserted on the same edge that RUN is entered is ignored, because state is still CLEAR at that edge.
- There is no backpressure. The consumer must not issue reads or writes while `ready`=0.

## Structure
- Package `gpr_pkg`:
  - state enum `gpr_state_e` {CLEAR, RUN}
  - function `gpr_aw(nreg)`
  - localparam `GPR_ZERO_IDX`=0
- Sub-module `gpr_read_port`, instantiated NRD times. It performs the array index plus the priority bypass mux over the NWR write ports and the zero/CLEAR forcing.
- The top level contains the register array, the write-priority loop, the clear FSM and counter, and the debug port.

## Test plan
- **Clear after reset.** Preload garbage into reg 5 via a hierarchical poke. Hold `rst`=0 for 3 cycles, then release.
  - Required: `ready`=0 for exactly 31 cycles, then 1.
  - Required: `dbg_addr`=5 reads 0.
- **Basic write/read.** In RUN, write 0xDEADBEEF_00000001 to reg 3 on port 0.
  - Required (`BYPASS`=1): `rdata[0]` with `raddr[0]`=3 equals that value in the same cycle and on every later cycle.
  - Required: `dbg_data` with `dbg_addr`=3 shows it only from the next cycle.
- **Register 0.** Write 0xFFFF on both ports to reg 0.
  - Required: every `rdata` port and `dbg_data` return 0 in the same cycle and the next cycle.
- **Write conflict.** Port 0 writes 0x11 and port 1 writes 0x22 to reg 7 in the same cycle.
  - Required: the bypass read returns 0x22, and reg 7 holds 0x22 afterwards.
- **Reset mid-clear.** Drop `rst` at clear cycle 10, then release.
  - Required: `ready` rises 31 cycles after the release, not earlier.
  - Required: a `wen` pulse to reg 4 during CLEAR leaves reg 4 = 0.
- **No bypass.** Build with `BYPASS`=0. Write 0x55 to reg 9 while reg 9 holds 0x44.
  - Required: the same-cycle read returns 0x44, and the next cycle returns 0x55.
